// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Package  : systolic_pkg
// Purpose  : Shared constants for the systolic-array buffer controllers.
// Revision : 1.0
// ============================================================================
package systolic_pkg;

    localparam int unsigned c_BANK_WORDS = 256;
    localparam int unsigned c_BANK_IDX_W = $clog2(c_BANK_WORDS);

    localparam logic [1:0] c_RD_IDLE  = 2'd0;
    localparam logic [1:0] c_RD_FETCH = 2'd1;
    localparam logic [1:0] c_RD_VALID = 2'd2;

endpackage
`default_nettype wire

// File: rtl/buf_pp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : buf_pp_ctrl
// Purpose  : Block buffer controller for a 1R1W RAM: host blocks in, array
//            blocks out. BUF_PP_CTRL_PINGPONG_EN selects two ping-pong banks;
//            otherwise the whole RAM is a single bank.
// Revision : 1.0
// ============================================================================
module buf_pp_ctrl
    import systolic_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADR_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              ram_wen,
    output logic [ADR_W-1:0]  ram_wadr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADR_W-1:0]  ram_radr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        bank_full
);

`ifdef BUF_PP_CTRL_PINGPONG_EN
    localparam int   IDX_W = int'(c_BANK_IDX_W);
    localparam logic c_PP  = 1'b1;
`else
    localparam int   IDX_W = ADR_W;
    localparam logic c_PP  = 1'b0;
`endif

    localparam logic [IDX_W-1:0] c_IDX_ONE = 1;
    localparam logic [IDX_W:0]   c_LEN_ONE = 1;

    logic [1:0]          r_state_q, w_state_d;
    logic                r_wb_q, w_wb_d;
    logic                r_rb_q, w_rb_d;
    logic [IDX_W-1:0]    r_wcnt_q, w_wcnt_d;
    logic [IDX_W-1:0]    r_rcnt_q, w_rcnt_d;
    logic [1:0][IDX_W:0] r_len_q, w_len_d;
    logic [1:0]          r_full_q, w_full_d;
    logic [1:0]          w_set, w_clr;
    logic                w_accept, w_close, w_hs, w_adv;

    assign wr_ready  = ~r_full_q[r_wb_q];
    assign w_accept  = wr_valid & wr_ready;
    assign w_close   = w_accept & (wr_last | (r_wcnt_q == '1));
    assign ram_wen   = w_accept;
    // In single-bank mode the bank bit falls off the top of the cast.
    assign ram_wadr  = ADR_W'({r_wb_q, r_wcnt_q});
    assign ram_wdata = wr_data;
    assign rd_data   = ram_rdata;
    assign w_hs      = rd_valid & rd_ready;
    assign bank_full = r_full_q;

    always_comb begin
        w_wb_d   = r_wb_q;
        w_wcnt_d = r_wcnt_q;
        w_len_d  = r_len_q;
        w_set    = '0;
        if (w_accept) begin
            w_wcnt_d = r_wcnt_q + c_IDX_ONE;
        end
        if (w_close) begin
            w_len_d[r_wb_q] = {1'b0, r_wcnt_q} + c_LEN_ONE;
            w_set[r_wb_q]   = 1'b1;
            w_wb_d          = r_wb_q ^ c_PP;
            w_wcnt_d        = '0;
        end
    end

    always_comb begin
        w_rb_d   = r_rb_q;
        w_rcnt_d = r_rcnt_q;
        w_clr    = '0;
        if (w_hs) begin
            if (rd_last) begin
                w_clr[r_rb_q] = 1'b1;
                w_rb_d        = r_rb_q ^ c_PP;
                w_rcnt_d      = '0;
            end else begin
                w_rcnt_d = r_rcnt_q + c_IDX_ONE;
            end
        end
        // Close and release always target different banks, so set/clear never collide.
        w_full_d = ((r_full_q | w_set) & ~w_clr) & {c_PP, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_q   <= 1'b0;
            r_rb_q   <= 1'b0;
            r_wcnt_q <= '0;
            r_rcnt_q <= '0;
            r_len_q  <= '0;
            r_full_q <= '0;
        end else begin
            r_wb_q   <= w_wb_d;
            r_rb_q   <= w_rb_d;
            r_wcnt_q <= w_wcnt_d;
            r_rcnt_q <= w_rcnt_d;
            r_len_q  <= w_len_d;
            r_full_q <= w_full_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= c_RD_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_RD_IDLE:  if (r_full_q[r_rb_q]) w_state_d = c_RD_FETCH;
            c_RD_FETCH: w_state_d = c_RD_VALID;
            c_RD_VALID: if (w_hs & rd_last) w_state_d = c_RD_IDLE;
            default:    w_state_d = c_RD_IDLE;
        endcase
    end

    // Read address runs one word ahead during a handshake so RAM latency is hidden.
    always_comb begin
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        if (r_state_q == c_RD_VALID) begin
            rd_valid = 1'b1;
            rd_last  = ({1'b0, r_rcnt_q} == (r_len_q[r_rb_q] - c_LEN_ONE));
        end
        w_adv    = rd_valid & rd_ready & ~rd_last;
        ram_radr = ADR_W'({r_rb_q, r_rcnt_q + IDX_W'(w_adv)});
    end

endmodule
`default_nettype wire

// File: tb/tb_buf_pp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_buf_pp_ctrl
// Purpose  : Self-checking bench for buf_pp_ctrl with a registered-read RAM
//            model and a block-level reference model (BUF_PP_CTRL_PINGPONG_EN aware).
// Revision : 1.0
// ============================================================================
module tb_buf_pp_ctrl;

`ifdef BUF_PP_CTRL_PINGPONG_EN
    localparam int         c_BANKS   = 2;
    localparam int         c_BSZ     = 256;
    localparam logic [1:0] c_BF_256  = 2'b01;
    localparam logic [1:0] c_BF_BOTH = 2'b11;
`else
    localparam int         c_BANKS   = 1;
    localparam int         c_BSZ     = 512;
    localparam logic [1:0] c_BF_256  = 2'b00;
    localparam logic [1:0] c_BF_BOTH = 2'b01;
`endif

    logic        clk, rst;
    logic        wr_valid, wr_last, wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid, rd_last, rd_ready;
    logic [15:0] rd_data;
    logic        ram_wen;
    logic [8:0]  ram_wadr, ram_radr;
    logic [15:0] ram_wdata, ram_rdata;
    logic [1:0]  bank_full;

    buf_pp_ctrl #(.DATA_W(16), .ADR_W(9)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
        .ram_wen(ram_wen), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata),
        .ram_radr(ram_radr), .ram_rdata(ram_rdata), .bank_full(bank_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [512];
    always @(posedge clk) begin
        if (ram_wen) mem[ram_wadr] <= ram_wdata;
        ram_rdata <= mem[ram_radr];
    end

    typedef struct packed { logic [15:0] d; logic l; } ent_t;
    ent_t        exp_q[$];
    logic [1:0]  m_full;
    int          m_wb, m_rb, m_wpos;
    logic        p_stall, p_last;
    logic [15:0] p_data;
    int          total = 0;
    int          bad   = 0;
    bit          wdone;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full  = 2'b00;
        m_wb    = 0;
        m_rb    = 0;
        m_wpos  = 0;
        p_stall = 1'b0;
        exp_q.delete();
    endtask

    // Block-level model: block k lands in bank k mod c_BANKS and is read back in write order.
    always @(negedge clk) begin
        logic acc, hs, exp_rdy, lst, rel;
        ent_t e;
        if (!rst) begin
            exp_rdy = !m_full[m_wb];
            acc     = wr_valid && exp_rdy;
            hs      = rd_valid && rd_ready;
            rel     = 1'b0;
            chk("bank_full", bank_full, m_full);
            chk("wr_ready", wr_ready, exp_rdy);
            chk("ram_wen", ram_wen, acc);
            chk("rd_valid_nonfull", rd_valid && !m_full[m_rb], 1'b0);
            if (acc) begin
                chk("ram_wadr", ram_wadr, m_wb * c_BSZ + m_wpos);
                chk("ram_wdata", ram_wdata, wr_data);
            end
            if (p_stall) begin
                chk("stall_valid", rd_valid, 1'b1);
                chk("stall_data", rd_data, p_data);
                chk("stall_last", rd_last, p_last);
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected", rd_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", rd_data, e.d);
                    chk("rd_last", rd_last, e.l);
                    rel = e.l;
                end
            end
            if (acc) begin
                lst = wr_last || (m_wpos == c_BSZ - 1);
                e.d = wr_data;
                e.l = lst;
                exp_q.push_back(e);
                if (lst) begin
                    m_full[m_wb] = 1'b1;
                    m_wb   = (m_wb + 1) % c_BANKS;
                    m_wpos = 0;
                end else begin
                    m_wpos++;
                end
            end
            if (rel) begin
                m_full[m_rb] = 1'b0;
                m_rb = (m_rb + 1) % c_BANKS;
            end
            p_stall = rd_valid && !rd_ready;
            p_data  = rd_data;
            p_last  = rd_last;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic put_word(input logic [15:0] d, input logic l, output logic [8:0] adr);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        @(negedge clk);
        while (!wr_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wr_accept_timeout", wr_ready, 1'b1);
        adr = ram_wadr;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        rd_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_ready = 1'b1;
        while ((exp_q.size() != 0 || rd_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] adr;
        int n;
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; rd_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_radr", ram_radr, 0);
        chk("rst_valid", rd_valid, 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_bank_full", bank_full, 2'b00);
        chk("init_rd_valid", rd_valid, 1'b0);
        chk("init_rd_last", rd_last, 1'b0);
        chk("init_ram_wen", ram_wen, 1'b0);
        chk("init_wr_ready", wr_ready, 1'b1);
        chk("init_ram_radr", ram_radr, 0);
        @(posedge clk);
        #1;

        // Four-word block, reader always ready: latency and streaming.
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put_word(16'(8'h11 + i), (i == 3), adr);
            chk("blk4_adr", adr, i);
        end
        chk("blk4_full", bank_full, 2'b01);
        for (int i = 0; i < 4; i++) chk("blk4_mem", mem[i], 16'(8'h11 + i));
        @(negedge clk);
        chk("lat_cycle0", rd_valid, 1'b0);
        @(negedge clk);
        chk("lat_cycle1", rd_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("blk4_valid", rd_valid, 1'b1);
            chk("blk4_data", rd_data, 16'(8'h11 + i));
            chk("blk4_last", rd_last, (i == 3));
        end
        @(negedge clk);
        chk("blk4_released", bank_full, 2'b00);
        chk("blk4_idle", rd_valid, 1'b0);
        @(posedge clk);
        #1;

        // 256 words without wr_last, then fill until the writer must stall.
        do_reset();
        for (int i = 0; i < 256; i++) put_word(16'($urandom), 1'b0, adr);
        chk("bf_after_256", bank_full, c_BF_256);
        put_word(16'($urandom), 1'b0, adr);
        chk("adr_word_257", adr, 256);
        put_word(16'hBEEF, 1'b1, adr);
        chk("bf_both", bank_full, c_BF_BOTH);
        chk("wr_ready_both", wr_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("wr_ready_hold", wr_ready, 1'b0);
        rd_ready = 1'b1;
        n = 0;
        while (bank_full[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("release_b0", bank_full[0], 1'b0);
        chk("wr_ready_release", wr_ready, 1'b1);
        @(posedge clk);
        #1;
        put_word(16'h0123, 1'b1, adr);
        chk("adr_after_release", adr, 0);
        drain();

        // Random block lengths, write gaps and reader back-pressure.
        do_reset();
        wdone = 1'b0;
        fork
            begin
                for (int b = 0; b < 30; b++) begin
                    int len;
                    len = $urandom_range(1, 40);
                    for (int j = 0; j < len; j++) begin
                        logic [8:0] a;
                        put_word(16'($urandom), (j == len - 1), a);
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                wdone = 1'b1;
            end
            begin
                int k;
                k = 0;
                while (!(wdone && exp_q.size() == 0) && k < 20000) begin
                    rd_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                    k++;
                end
                rd_ready = 1'b1;
            end
        join
        drain();

`ifdef BUF_PP_CTRL_PINGPONG_EN
        // Bank 1 closes in the very cycle bank 0 is released.
        do_reset();
        put_word(16'h00A0, 1'b0, adr);
        put_word(16'h00A1, 1'b0, adr);
        put_word(16'h00A2, 1'b1, adr);
        put_word(16'h00B0, 1'b0, adr);
        put_word(16'h00B1, 1'b0, adr);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rd_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("bf_pre_swap", bank_full, 2'b01);
        put_word(16'h00B2, 1'b1, adr);
        chk("bf_swap", bank_full, 2'b10);
        drain();
`endif

        // Reset in the middle of a read, then a single-word block.
        do_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) put_word(16'(16'h0200 + i), (i == 9), adr);
        n = 0;
        while (!rd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_read_valid", rd_valid, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_valid", rd_valid, 1'b0);
        chk("async_rst_last", rd_last, 1'b0);
        chk("async_rst_full", bank_full, 2'b00);
        chk("async_rst_radr", ram_radr, 0);
        chk("async_rst_wen", ram_wen, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        put_word(16'h5A5A, 1'b1, adr);
        chk("post_rst_adr", adr, 0);
        n = 0;
        while (!rd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("single_valid", rd_valid, 1'b1);
        chk("single_last", rd_last, 1'b1);
        chk("single_data", rd_data, 16'h5A5A);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
